// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipeline_pkg;

    // Controller FSM encodings
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

    localparam int REG_BITS_DEFAULT = 4;
    localparam int ZERO_REG         = 0;

endpackage

// File: rtl/hazard_wait_timer.sv
// Counts consecutive frozen cycles of an outstanding memory access and
// flags when the last allowed cycle has been reached.
module hazard_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,   // first frozen cycle: counter becomes 1
    input  logic inc_i,     // another frozen cycle inside the wait
    input  logic clr_i,     // access released or pipeline running
    output logic expire_o
);
    localparam int CNT_W = $clog2(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    assign expire_o = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

    // Next count: clear dominates, start loads 1, increment stops at terminal count
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr_i) begin
            wait_cnt_d = '0;
        end else if (start_i) begin
            wait_cnt_d = CNT_W'(1);
        end else if (inc_i && !expire_o) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/freeze controller: load-use bubbles between ID and EX, pipeline
// freeze while the data memory is busy, and a sticky timeout fault.
// Optional stall counter enabled by defining HAZARD_STALL_COUNT_EN.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int REG_BITS = REG_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] ID_RegisterRs,
    input  logic [REG_BITS-1:0] ID_RegisterRt,
    input  logic                ID_UsesRt,
    input  logic                EX_MR,
    input  logic                EX_EnRW,
    input  logic [REG_BITS-1:0] EX_RegisterRd,
    input  logic                MEM_MR,
    input  logic                MEM_MW,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                IFIDWrite,
    output logic                IDEXBubble,
    output logic                PipeFreeze,
    output logic                MemTimeout
`ifdef HAZARD_STALL_COUNT_EN
   ,output logic [31:0]         StallCount
`endif
);

    state_e state_q, state_d;
    logic   mem_timeout_q;
    logic   load_use, mem_wait;
    logic   tmr_start, tmr_inc, tmr_clr, tmr_expire;

    assign load_use = EX_MR & EX_EnRW & (EX_RegisterRd != REG_BITS'(ZERO_REG)) &
                      ((EX_RegisterRd == ID_RegisterRs) |
                       (ID_UsesRt & (EX_RegisterRd == ID_RegisterRt)));
    assign mem_wait = (MEM_MR | MEM_MW) & ~MemReady;

    assign MemTimeout = mem_timeout_q;

    hazard_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .start_i  (tmr_start),
        .inc_i    (tmr_inc),
        .clr_i    (tmr_clr),
        .expire_o (tmr_expire)
    );

    // Mealy decode of stall/freeze outputs and next state; reset forces run outputs
    always_comb begin
        state_d    = state_q;
        tmr_start  = 1'b0;
        tmr_inc    = 1'b0;
        tmr_clr    = 1'b0;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        PipeFreeze = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    PipeFreeze = 1'b1;
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    state_d    = MEM_WAIT;
                    tmr_start  = 1'b1;
                end else begin
                    tmr_clr = 1'b1;
                    if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!MemReady) begin
                    PipeFreeze = 1'b1;
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    if (tmr_expire) state_d = FAULT;
                    else            tmr_inc = 1'b1;
                end else begin
                    // release cycle behaves like a clean RUN cycle, bubble included
                    state_d = RUN;
                    tmr_clr = 1'b1;
                    if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
            end
            FAULT: begin
                PipeFreeze = 1'b1;
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IDEXBubble = 1'b0;
            PipeFreeze = 1'b0;
        end
    end

    // State and sticky fault flag; only reset leaves FAULT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= (state_d == FAULT);
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;
    assign StallCount = stall_cnt_q;

    // Saturating count of edges where the PC was held
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!PCWrite && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MAX_WAIT=4).
module tb_pipeline_hazard_controller;
    import pipeline_pkg::*;

    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [RB-1:0] ID_RegisterRs, ID_RegisterRt, EX_RegisterRd;
    logic          ID_UsesRt, EX_MR, EX_EnRW, MEM_MR, MEM_MW, MemReady;
    logic          PCWrite, IFIDWrite, IDEXBubble, PipeFreeze, MemTimeout;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0]   StallCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipeline_hazard_controller #(.MAX_WAIT(4), .REG_BITS(RB)) dut (
        .clk           (clk),
        .reset         (reset),
        .ID_RegisterRs (ID_RegisterRs),
        .ID_RegisterRt (ID_RegisterRt),
        .ID_UsesRt     (ID_UsesRt),
        .EX_MR         (EX_MR),
        .EX_EnRW       (EX_EnRW),
        .EX_RegisterRd (EX_RegisterRd),
        .MEM_MR        (MEM_MR),
        .MEM_MW        (MEM_MW),
        .MemReady      (MemReady),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEXBubble    (IDEXBubble),
        .PipeFreeze    (PipeFreeze),
        .MemTimeout    (MemTimeout)
`ifdef HAZARD_STALL_COUNT_EN
       ,.StallCount    (StallCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {PCWrite, IFIDWrite, IDEXBubble, PipeFreeze}
    task automatic chk_out(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, PCWrite, IFIDWrite, IDEXBubble, PipeFreeze}, {28'd0, exp});
    endtask

    task automatic chk_sc(input string tag, input logic [31:0] exp);
`ifdef HAZARD_STALL_COUNT_EN
        chk(tag, StallCount, exp);
`endif
    endtask

    // advance one edge, then let inputs settle a moment after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ID_RegisterRs = '0; ID_RegisterRt = '0; EX_RegisterRd = '0;
        ID_UsesRt = 0; EX_MR = 0; EX_EnRW = 0;
        MEM_MR = 0; MEM_MW = 0; MemReady = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr_in();
        #2;
        chk_out("reset_outputs", 4'b1100);
        tick();
        chk("reset_state", dut.state_q, RUN);
        chk("reset_timeout", MemTimeout, 0);
        chk_sc("reset_stallcount", 0);
        reset = 1'b0;

        // load-use on Rs: one-cycle bubble
        EX_MR = 1; EX_EnRW = 1; EX_RegisterRd = 3; ID_RegisterRs = 3;
        #1 chk_out("lu_rs_stall", 4'b0010);
        tick();
        EX_MR = 0;
        #1 chk_out("lu_rs_release", 4'b1100);
        chk_sc("lu_stallcount", 1);

        // false-stall filters, all within one cycle
        EX_MR = 1; EX_EnRW = 1; EX_RegisterRd = 0; ID_RegisterRs = 0;
        #1 chk_out("rd_zero_no_stall", 4'b1100);
        EX_RegisterRd = 5; ID_RegisterRs = 1; ID_RegisterRt = 5; ID_UsesRt = 0;
        #1 chk_out("rt_unused_no_stall", 4'b1100);
        ID_UsesRt = 1;
        #1 chk_out("rt_used_stall", 4'b0010);
        EX_EnRW = 0;
        #1 chk_out("no_enrw_no_stall", 4'b1100);
        clr_in();

        // memory wait of 3 cycles, counted from a fresh reset
        reset = 1; tick(); reset = 0;
        MEM_MR = 1; MemReady = 0;
        #1 chk_out("mw_c0", 4'b0001);
        tick();
        chk_out("mw_c1", 4'b0001);
        chk("mw_cnt1", 32'(dut.u_timer.wait_cnt_q), 1);
        tick();
        chk_out("mw_c2", 4'b0001);
        tick();
        MemReady = 1;
        #1 chk_out("mw_release", 4'b1100);
        tick();
        clr_in();
        chk("mw_state_run", dut.state_q, RUN);
        chk("mw_cnt_clear", 32'(dut.u_timer.wait_cnt_q), 0);
        chk_sc("mw_stallcount", 3);
        #1 chk_out("mw_after", 4'b1100);

        // wait with load-use held: bubble only on the release cycle
        EX_MR = 1; EX_EnRW = 1; EX_RegisterRd = 3; ID_RegisterRs = 3;
        MEM_MR = 1; MemReady = 0;
        #1 chk_out("wlu_c0", 4'b0001);
        tick();
        chk_out("wlu_c1", 4'b0001);
        tick();
        MemReady = 1;
        #1 chk_out("wlu_release_bubble", 4'b0010);
        tick();
        clr_in();
        #1 chk_out("wlu_after", 4'b1100);

        // timeout with MAX_WAIT=4
        MEM_MW = 1; MemReady = 0;
        for (int c = 0; c < 4; c++) begin
            #1 chk_out($sformatf("to_frozen_c%0d", c), 4'b0001);
            chk($sformatf("to_no_fault_c%0d", c), MemTimeout, 0);
            if (c == 3) chk("to_cnt_term", 32'(dut.u_timer.wait_cnt_q), 3);
            tick();
        end
        chk("to_fault_c4", MemTimeout, 1);
        chk("to_state_fault", dut.state_q, FAULT);
        chk_out("to_fault_out", 4'b0001);
        MemReady = 1;
        #1 chk_out("to_ready_ignored", 4'b0001);
        tick();
        chk("to_still_fault", MemTimeout, 1);
        reset = 1;
        #1 chk_out("to_reset_outputs", 4'b1100);
        tick();
        reset = 0; MEM_MW = 0; MemReady = 0;
        #1 chk("to_fault_cleared", MemTimeout, 0);
        chk_out("to_after_reset", 4'b1100);

        // reset during the second MEM_WAIT cycle
        MEM_MR = 1; MemReady = 0;
        tick();
        tick();
        chk("rmw_cnt_before", 32'(dut.u_timer.wait_cnt_q), 2);
        reset = 1;
        #1 chk_out("rmw_reset_outputs", 4'b1100);
        tick();
        chk("rmw_state_run", dut.state_q, RUN);
        chk("rmw_cnt_zero", 32'(dut.u_timer.wait_cnt_q), 0);
        chk_sc("rmw_stallcount", 0);
        reset = 0; MEM_MR = 0;
        #1 chk_out("rmw_after", 4'b1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
